wb_stage: RTL and testbench

Final pipeline stage, directly downstream of MEM. Captures each instruction MEM hands over. For loads, it also captures the bus read word in the same edge as `data_data_ok`. It performs load byte selection, sign/zero extension and LWL/LWR merging, then drives the GPR write port, the ID forwarding path and the debug trace. It also owns the exception-risk interlock back to MEM, a one-cycle settle bubble after dangerous instructions, and a retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 23 ++
 rtl/wb_stage_if.sv | 38 +++
 rtl/wb_stage_load_align.sv | 60 ++++++
 rtl/wb_stage.sv | 142 ++++++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, load-select bit indices and settle-FSM state
// encodings for the write-back stage and its load alignment helper.
package wb_stage_pkg;

    localparam int GPR_W      = 5;
    localparam int WORD_W     = 32;
    localparam int LOAD_SEL_W = 7;

    // One-hot load select: {LWR,LWL,LW,LHU,LH,LBU,LB}
    localparam int LOAD_LB_BIT  = 0;
    localparam int LOAD_LBU_BIT = 1;
    localparam int LOAD_LH_BIT  = 2;
    localparam int LOAD_LHU_BIT = 3;
    localparam int LOAD_LW_BIT  = 4;
    localparam int LOAD_LWL_BIT = 5;
    localparam int LOAD_LWR_BIT = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BUBBLE = 1'b1
    } settle_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM -> WB hand-over bundle.
//   master : MEM side, drives MEM_* payload and valid, observes WB_allowin_w_o
//   slave  : WB side, samples MEM_* and drives WB_allowin_w_o
//
// Handshake: an instruction transfers on every rising edge where
// MEM_valid_w_i && WB_allowin_w_o. While MEM_valid_w_i=1 and
// WB_allowin_w_o=0, MEM holds valid and the whole payload stable.
// WB_allowin_w_o is registered and never depends on MEM_valid_w_i.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic                  MEM_valid_w_i;
    logic [GPR_W-1:0]      MEM_writeNum_i;
    logic [WORD_W-1:0]     MEM_finalRes_i;
    logic [WORD_W-1:0]     MEM_VAddr_i;
    logic [WORD_W-1:0]     MEM_rtData_i;
    logic                  MEM_memReq_i;
    logic [LOAD_SEL_W-1:0] MEM_loadSel_i;
    logic [1:0]            MEM_alignCheck_i;
    logic                  MEM_isDangerous_i;
    logic                  MEM_exceptionRisk_i;
    logic                  WB_allowin_w_o;

    modport master (
        output MEM_valid_w_i, MEM_writeNum_i, MEM_finalRes_i, MEM_VAddr_i,
               MEM_rtData_i, MEM_memReq_i, MEM_loadSel_i, MEM_alignCheck_i,
               MEM_isDangerous_i, MEM_exceptionRisk_i,
        input  WB_allowin_w_o
    );

    modport slave (
        input  MEM_valid_w_i, MEM_writeNum_i, MEM_finalRes_i, MEM_VAddr_i,
               MEM_rtData_i, MEM_memReq_i, MEM_loadSel_i, MEM_alignCheck_i,
               MEM_isDangerous_i, MEM_exceptionRisk_i,
        output WB_allowin_w_o
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load result formatting.
//   load_sel_i : one-hot load type (0 = not a load, result is don't-care)
//   align_i    : vaddr[1:0]
//   word_i     : aligned bus read word
//   rt_i       : old rt value, merged by LWL/LWR
//   result_o   : value to write to the GPR
// Kept free of state so an early-forward path can reuse it.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [LOAD_SEL_W-1:0] load_sel_i,
    input  logic [1:0]            align_i,
    input  logic [WORD_W-1:0]     word_i,
    input  logic [WORD_W-1:0]     rt_i,
    output logic [WORD_W-1:0]     result_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = word_i[7:0];
        case (align_i)
            2'd0: byte_w = word_i[7:0];
            2'd1: byte_w = word_i[15:8];
            2'd2: byte_w = word_i[23:16];
            2'd3: byte_w = word_i[31:24];
            default: byte_w = word_i[7:0];
        endcase
        half_w = align_i[1] ? word_i[31:16] : word_i[15:0];

        result_o = word_i;
        if (load_sel_i[LOAD_LB_BIT]) begin
            result_o = {{24{byte_w[7]}}, byte_w};
        end else if (load_sel_i[LOAD_LBU_BIT]) begin
            result_o = {24'd0, byte_w};
        end else if (load_sel_i[LOAD_LH_BIT]) begin
            result_o = {{16{half_w[15]}}, half_w};
        end else if (load_sel_i[LOAD_LHU_BIT]) begin
            result_o = {16'd0, half_w};
        end else if (load_sel_i[LOAD_LWL_BIT]) begin
            // Big-end fragment of the unaligned word lands in the high bytes
            case (align_i)
                2'd0: result_o = {word_i[7:0],  rt_i[23:0]};
                2'd1: result_o = {word_i[15:0], rt_i[15:0]};
                2'd2: result_o = {word_i[23:0], rt_i[7:0]};
                default: result_o = word_i;
            endcase
        end else if (load_sel_i[LOAD_LWR_BIT]) begin
            // Little-end fragment of the unaligned word lands in the low bytes
            case (align_i)
                2'd1: result_o = {rt_i[31:24], word_i[31:8]};
                2'd2: result_o = {rt_i[31:16], word_i[31:16]};
                2'd3: result_o = {rt_i[31:8],  word_i[31:24]};
                default: result_o = word_i;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage after MEM.
//   clk, rst             : clock, asynchronous active-low reset
//   mem_if (slave)       : MEM hand-over payload/valid in, WB_allowin_w_o out
//   data_rdata           : bus read word, captured with a memory instruction
//   WB_rfWen_o/Wnum/Wdata: GPR write port
//   WB_writeNum_w_o, WB_forwardData_w_o : ID forwarding path
//   WB_hasRisk_w_o       : exception-risk interlock back to MEM
//   debug_wb_*           : commit trace, mirrors the GPR write port
//   WB_retireCnt_o       : retired-instruction counter
//   WB_settleState_o     : settle FSM state for observation
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    wb_stage_if.slave           mem_if,
    input  logic [WORD_W-1:0]   data_rdata,
    output logic                WB_hasRisk_w_o,
    output logic                WB_rfWen_o,
    output logic [GPR_W-1:0]    WB_rfWnum_o,
    output logic [WORD_W-1:0]   WB_rfWdata_o,
    output logic [GPR_W-1:0]    WB_writeNum_w_o,
    output logic [WORD_W-1:0]   WB_forwardData_w_o,
    output logic [WORD_W-1:0]   debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [GPR_W-1:0]    debug_wb_rf_wnum,
    output logic [WORD_W-1:0]   debug_wb_rf_wdata,
    output logic [WORD_W-1:0]   WB_retireCnt_o,
    output settle_state_e       WB_settleState_o
);

    logic                  has_data_q, has_data_d;
    logic [GPR_W-1:0]      write_num_q;
    logic [WORD_W-1:0]     final_res_q;
    logic [WORD_W-1:0]     vaddr_q;
    logic [WORD_W-1:0]     rt_data_q;
    logic [LOAD_SEL_W-1:0] load_sel_q;
    logic [1:0]            align_q;
    logic                  dangerous_q;
    logic                  risk_q;
    logic [WORD_W-1:0]     ld_word_q;
    logic [WORD_W-1:0]     retire_cnt_q, retire_cnt_d;
    settle_state_e         state_q;
    logic                  allowin_q;

    logic                  take;
    logic [WORD_W-1:0]     load_res;
    logic [WORD_W-1:0]     wdata;
    logic                  rf_wen;

    assign take = mem_if.MEM_valid_w_i && allowin_q;

    // Without a take, WB only empties when it was open; while the bubble
    // holds allowin low the occupancy bit is left alone.
    assign has_data_d   = take ? 1'b1 : (allowin_q ? 1'b0 : has_data_q);
    assign retire_cnt_d = retire_cnt_q + {{(WORD_W-1){1'b0}}, has_data_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            has_data_q   <= 1'b0;
            write_num_q  <= '0;
            final_res_q  <= '0;
            vaddr_q      <= '0;
            rt_data_q    <= '0;
            load_sel_q   <= '0;
            align_q      <= '0;
            dangerous_q  <= 1'b0;
            risk_q       <= 1'b0;
            ld_word_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            has_data_q   <= has_data_d;
            retire_cnt_q <= retire_cnt_d;
            if (take) begin
                write_num_q <= mem_if.MEM_writeNum_i;
                final_res_q <= mem_if.MEM_finalRes_i;
                vaddr_q     <= mem_if.MEM_VAddr_i;
                rt_data_q   <= mem_if.MEM_rtData_i;
                load_sel_q  <= mem_if.MEM_loadSel_i;
                align_q     <= mem_if.MEM_alignCheck_i;
                dangerous_q <= mem_if.MEM_isDangerous_i;
                risk_q      <= mem_if.MEM_exceptionRisk_i;
                // data_ok coincides with the hand-over of a memory access
                if (mem_if.MEM_memReq_i) begin
                    ld_word_q <= data_rdata;
                end
            end
        end
    end

    // Settle FSM: a dangerous instruction leaving WB without a successor
    // closes allowin for one cycle so its side effects settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            allowin_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (has_data_q && dangerous_q && !take) begin
                        state_q   <= ST_BUBBLE;
                        allowin_q <= 1'b0;
                    end
                end
                ST_BUBBLE: begin
                    state_q   <= ST_IDLE;
                    allowin_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    allowin_q <= 1'b1;
                end
            endcase
        end
    end

    load_align u_load_align (
        .load_sel_i (load_sel_q),
        .align_i    (align_q),
        .word_i     (ld_word_q),
        .rt_i       (rt_data_q),
        .result_o   (load_res)
    );

    assign wdata  = (|load_sel_q) ? load_res : final_res_q;
    assign rf_wen = has_data_q && (|write_num_q);

    assign mem_if.WB_allowin_w_o = allowin_q;
    assign WB_hasRisk_w_o        = has_data_q && risk_q;
    assign WB_rfWen_o            = rf_wen;
    assign WB_rfWnum_o           = write_num_q;
    assign WB_rfWdata_o          = wdata;
    assign WB_writeNum_w_o       = has_data_q ? write_num_q : '0;
    assign WB_forwardData_w_o    = wdata;
    assign debug_wb_pc           = vaddr_q;
    assign debug_wb_rf_wen       = {4{rf_wen}};
    assign debug_wb_rf_wnum      = write_num_q;
    assign debug_wb_rf_wdata     = wdata;
    assign WB_retireCnt_o        = retire_cnt_q;
    assign WB_settleState_o      = state_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic [31:0] data_rdata;

    logic        WB_hasRisk_w_o;
    logic        WB_rfWen_o;
    logic [4:0]  WB_rfWnum_o;
    logic [31:0] WB_rfWdata_o;
    logic [4:0]  WB_writeNum_w_o;
    logic [31:0] WB_forwardData_w_o;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] WB_retireCnt_o;
    settle_state_e WB_settleState_o;

    wb_stage_if mem_if();

    wb_stage dut (
        .clk                (clk),
        .rst                (rst),
        .mem_if             (mem_if),
        .data_rdata         (data_rdata),
        .WB_hasRisk_w_o     (WB_hasRisk_w_o),
        .WB_rfWen_o         (WB_rfWen_o),
        .WB_rfWnum_o        (WB_rfWnum_o),
        .WB_rfWdata_o       (WB_rfWdata_o),
        .WB_writeNum_w_o    (WB_writeNum_w_o),
        .WB_forwardData_w_o (WB_forwardData_w_o),
        .debug_wb_pc        (debug_wb_pc),
        .debug_wb_rf_wen    (debug_wb_rf_wen),
        .debug_wb_rf_wnum   (debug_wb_rf_wnum),
        .debug_wb_rf_wdata  (debug_wb_rf_wdata),
        .WB_retireCnt_o     (WB_retireCnt_o),
        .WB_settleState_o   (WB_settleState_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [68:0] exp_q[$];   // {pc, wnum, wdata}

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: every committed GPR write must match the oldest expectation.
    always @(negedge clk) begin
        logic [68:0] e;
        if (rst && WB_rfWen_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: pc=%h wnum=%0d wdata=%h", debug_wb_pc, WB_rfWnum_o, WB_rfWdata_o);
            end else begin
                e = exp_q.pop_front();
                if ({debug_wb_pc, WB_rfWnum_o, WB_rfWdata_o} !== e ||
                    debug_wb_rf_wen !== 4'hF || debug_wb_rf_wnum !== e[36:32] ||
                    debug_wb_rf_wdata !== e[31:0] || WB_forwardData_w_o !== e[31:0] ||
                    WB_writeNum_w_o !== e[36:32]) begin
                    bad++;
                    $display("FAIL write_port: got pc=%h wnum=%0d wdata=%h dbg_wen=%h fwd_num=%0d fwd=%h expected pc=%h wnum=%0d wdata=%h",
                             debug_wb_pc, WB_rfWnum_o, WB_rfWdata_o, debug_wb_rf_wen, WB_writeNum_w_o,
                             WB_forwardData_w_o, e[68:37], e[36:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_bus();
        mem_if.MEM_valid_w_i       = 1'b0;
        mem_if.MEM_writeNum_i      = '0;
        mem_if.MEM_finalRes_i      = '0;
        mem_if.MEM_VAddr_i         = '0;
        mem_if.MEM_rtData_i        = '0;
        mem_if.MEM_memReq_i        = 1'b0;
        mem_if.MEM_loadSel_i       = '0;
        mem_if.MEM_alignCheck_i    = '0;
        mem_if.MEM_isDangerous_i   = 1'b0;
        mem_if.MEM_exceptionRisk_i = 1'b0;
        data_rdata                 = 32'h0;
    endtask

    // Called at a negedge; returns at the negedge of the cycle in which the
    // instruction occupies WB.
    task automatic issue(input logic [4:0] wnum, input logic [31:0] fres, input logic [31:0] pc,
                         input logic [31:0] rt, input logic mreq, input logic [6:0] lsel,
                         input logic [1:0] al, input logic dang, input logic risk,
                         input logic [31:0] rdata, input logic [31:0] exp_wdata);
        int n;
        mem_if.MEM_valid_w_i       = 1'b1;
        mem_if.MEM_writeNum_i      = wnum;
        mem_if.MEM_finalRes_i      = fres;
        mem_if.MEM_VAddr_i         = pc;
        mem_if.MEM_rtData_i        = rt;
        mem_if.MEM_memReq_i        = mreq;
        mem_if.MEM_loadSel_i       = lsel;
        mem_if.MEM_alignCheck_i    = al;
        mem_if.MEM_isDangerous_i   = dang;
        mem_if.MEM_exceptionRisk_i = risk;
        data_rdata                 = rdata;
        n = 0;
        while (!mem_if.WB_allowin_w_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: pc=%h not accepted within 8 cycles", pc);
        end else if (wnum != 5'd0) begin
            exp_q.push_back({pc, wnum, exp_wdata});
        end
        @(negedge clk);
        idle_bus();
    endtask

    // ---------------- directed sequence ----------------
    int d_cyc, s_cyc;

    initial begin
        idle_bus();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_rfwen",    32'(WB_rfWen_o), 32'd0);
        check("rst_dbgwen",   32'(debug_wb_rf_wen), 32'd0);
        check("rst_fwdnum",   32'(WB_writeNum_w_o), 32'd0);
        check("rst_risk",     32'(WB_hasRisk_w_o), 32'd0);
        check("rst_allowin",  32'(mem_if.WB_allowin_w_o), 32'd1);
        check("rst_cnt",      WB_retireCnt_o, 32'd0);
        check("rst_state",    32'(WB_settleState_o), 32'(ST_IDLE));
        check("rst_pc",       debug_wb_pc, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Loads and ALU result, back to back (write data checked by monitor)
        issue(5'd3,  32'h5A5A5A5A, 32'h100, 32'h0,        1'b1, 7'b0000001, 2'd3, 1'b0, 1'b0, 32'h80123456, 32'hFFFFFF80);
        issue(5'd4,  32'h5A5A5A5A, 32'h104, 32'h0,        1'b1, 7'b0000010, 2'd3, 1'b0, 1'b0, 32'h80123456, 32'h00000080);
        issue(5'd5,  32'h5A5A5A5A, 32'h108, 32'h11223344, 1'b1, 7'b0100000, 2'd1, 1'b0, 1'b0, 32'hAABBCCDD, 32'hCCDD3344);
        issue(5'd6,  32'h5A5A5A5A, 32'h10C, 32'h11223344, 1'b1, 7'b1000000, 2'd2, 1'b0, 1'b0, 32'hAABBCCDD, 32'h1122AABB);
        issue(5'd7,  32'h5A5A5A5A, 32'h110, 32'h0,        1'b1, 7'b0000100, 2'd2, 1'b0, 1'b0, 32'h80017FFF, 32'hFFFF8001);
        issue(5'd8,  32'h5A5A5A5A, 32'h114, 32'h0,        1'b1, 7'b0001000, 2'd0, 1'b0, 1'b0, 32'h80017FFF, 32'h00007FFF);
        issue(5'd9,  32'h5A5A5A5A, 32'h118, 32'h0,        1'b1, 7'b0010000, 2'd0, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
        issue(5'd10, 32'hDEADBEEF, 32'h11C, 32'h0,        1'b0, 7'b0000000, 2'd0, 1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF);
        issue(5'd11, 32'h5A5A5A5A, 32'h120, 32'h11223344, 1'b1, 7'b0100000, 2'd0, 1'b0, 1'b0, 32'hAABBCCDD, 32'hDD223344);
        issue(5'd12, 32'h5A5A5A5A, 32'h124, 32'h11223344, 1'b1, 7'b1000000, 2'd3, 1'b0, 1'b0, 32'hAABBCCDD, 32'h112233AA);
        @(negedge clk);
        check("cnt_after_10", WB_retireCnt_o, 32'd10);
        check("empty_fwdnum", 32'(WB_writeNum_w_o), 32'd0);

        // writeNum = 0: no write, but still retires
        issue(5'd0, 32'h5, 32'h130, 32'h0, 1'b0, 7'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h5);
        check("wnum0_rfwen",  32'(WB_rfWen_o), 32'd0);
        check("wnum0_dbgwen", 32'(debug_wb_rf_wen), 32'd0);
        @(negedge clk);
        check("wnum0_cnt", WB_retireCnt_o, 32'd11);

        // Exception-risk interlock
        issue(5'd8, 32'h77, 32'h134, 32'h0, 1'b0, 7'b0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h77);
        check("risk_set", 32'(WB_hasRisk_w_o), 32'd1);
        @(negedge clk);
        check("risk_clear", 32'(WB_hasRisk_w_o), 32'd0);

        // Dangerous instruction leaving alone: one-cycle bubble, successor
        // held by MEM during the bubble enters WB three cycles later.
        issue(5'd9, 32'hD0, 32'h200, 32'h0, 1'b0, 7'b0, 2'd0, 1'b1, 1'b0, 32'h0, 32'hD0);
        d_cyc = cyc;
        check("dang_allowin", 32'(mem_if.WB_allowin_w_o), 32'd1);
        @(negedge clk);
        check("bubble_allowin", 32'(mem_if.WB_allowin_w_o), 32'd0);
        check("bubble_state",   32'(WB_settleState_o), 32'(ST_BUBBLE));
        issue(5'd13, 32'hC0, 32'h204, 32'h0, 1'b0, 7'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'hC0);
        s_cyc = cyc;
        check("bubble_gap", 32'(s_cyc - d_cyc), 32'd3);
        check("after_bubble_allowin", 32'(mem_if.WB_allowin_w_o), 32'd1);

        // Dangerous instruction immediately followed: WB reloaded, no bubble
        issue(5'd14, 32'hD1, 32'h300, 32'h0, 1'b0, 7'b0, 2'd0, 1'b1, 1'b0, 32'h0, 32'hD1);
        d_cyc = cyc;
        issue(5'd15, 32'hC1, 32'h304, 32'h0, 1'b0, 7'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'hC1);
        s_cyc = cyc;
        check("reload_gap", 32'(s_cyc - d_cyc), 32'd1);
        check("reload_state", 32'(WB_settleState_o), 32'(ST_IDLE));
        @(negedge clk);

        // Asynchronous reset mid-cycle with WB occupied by a dangerous instruction
        issue(5'd10, 32'hE0, 32'h400, 32'h0, 1'b0, 7'b0, 2'd0, 1'b1, 1'b1, 32'h0, 32'hE0);
        #2 rst = 1'b0;
        #1;
        check("arst_rfwen",   32'(WB_rfWen_o), 32'd0);
        check("arst_dbgwen",  32'(debug_wb_rf_wen), 32'd0);
        check("arst_fwdnum",  32'(WB_writeNum_w_o), 32'd0);
        check("arst_risk",    32'(WB_hasRisk_w_o), 32'd0);
        check("arst_cnt",     WB_retireCnt_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_release_allowin", 32'(mem_if.WB_allowin_w_o), 32'd1);
        check("arst_release_state",   32'(WB_settleState_o), 32'(ST_IDLE));

        // Asynchronous reset in the middle of the bubble
        issue(5'd11, 32'hE1, 32'h500, 32'h0, 1'b0, 7'b0, 2'd0, 1'b1, 1'b0, 32'h0, 32'hE1);
        @(negedge clk);
        check("pre_arst_bubble", 32'(mem_if.WB_allowin_w_o), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_bubble_allowin", 32'(mem_if.WB_allowin_w_o), 32'd1);
        check("arst_bubble_state",   32'(WB_settleState_o), 32'(ST_IDLE));
        check("arst_bubble_cnt",     WB_retireCnt_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_bubble_release", 32'(mem_if.WB_allowin_w_o), 32'd1);

        // Counter wrap
        issue(5'd12, 32'h1, 32'h600, 32'h0, 1'b0, 7'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h1);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt_q;
        @(negedge clk);
        check("cnt_wrap", WB_retireCnt_o, 32'd0);

        repeat (2) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
